// File: rtl/img_proc_pkg.sv
// Shared image-pipeline definitions: pixel size, feeder FSM states, checksum width.
`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif

package img_proc_pkg;

  localparam int CHECKSUM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } feeder_state_e;

endpackage

// File: rtl/pixel_checksum.sv
// Running modulo-2^16 sum of every COLOR_SIZE-bit pixel in each valid word.
module pixel_checksum
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      vld,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic [CHECKSUM_WIDTH-1:0] checksum
);

  localparam int NPIX = DATA_WIDTH / `COLOR_SIZE;

  logic [CHECKSUM_WIDTH-1:0] word_sum;

  always_comb begin
    word_sum = '0;
    for (int i = 0; i < NPIX; i++) begin
      word_sum = word_sum + CHECKSUM_WIDTH'(data[i*`COLOR_SIZE +: `COLOR_SIZE]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (clr) begin
      checksum <= '0;
    end else if (vld) begin
      checksum <= checksum + word_sum;
    end
  end

endmodule

// File: rtl/pixel_feeder.sv
// Streams num_words image words from memory to the brightness processor (fixed 2-cycle latency).
// Define PIXEL_FEEDER_CHECKSUM_EN to add the pixel checksum output.
module pixel_feeder
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     num_words,
  input  logic                      hold,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      vld,
  output logic                      last_data,
  output logic                      busy,
  output logic                      done
`ifdef PIXEL_FEEDER_CHECKSUM_EN
  ,
  output logic [CHECKSUM_WIDTH-1:0] checksum
`endif
);

  feeder_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_q, nwords_q, issued_q;
  logic                  start_ok, rd_en, rd_last;
  logic                  vld_p1, last_p1;

  // Only IDLE accepts a start, so starts during a transfer or in FINISH are dropped.
  assign start_ok = (state == IDLE) && start;
  assign rd_last  = (issued_q == nwords_q - ADDR_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = (num_words == '0) ? FINISH : READ;
      READ: begin
        rd_en = !hold;
        if (!hold && rd_last) state_nxt = DRAIN;
      end
      DRAIN:  if (vld && last_data) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? base_q + issued_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      nwords_q <= '0;
      issued_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (start_ok) begin
        base_q   <= base_addr;
        nwords_q <= num_words;
        issued_q <= '0;
        busy     <= 1'b1;
      end else begin
        if (rd_en)             issued_q <= issued_q + ADDR_WIDTH'(1);
        if (state == FINISH)   busy     <= 1'b0;
      end
    end
  end

  // p1: read issued last cycle, memory data valid now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_en;
      last_p1 <= rd_en && rd_last;
    end
  end

  // output register: data_out is forced to zero whenever vld is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= 1'b0;
      last_data <= 1'b0;
      data_out  <= '0;
    end else begin
      vld       <= vld_p1;
      last_data <= last_p1;
      data_out  <= vld_p1 ? mem_rd_data : '0;
    end
  end

`ifdef PIXEL_FEEDER_CHECKSUM_EN
  pixel_checksum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checksum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .vld      (vld),
    .data     (data_out),
    .checksum (checksum)
  );
`endif

endmodule

// File: tb/tb_pixel_feeder.sv
// Scoreboard bench for pixel_feeder: directed transfers, address/data queues checked by a monitor.
`timescale 1ns/1ps
module tb_pixel_feeder;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] data_out;
  logic          vld, last_data, busy, done;
`ifdef PIXEL_FEEDER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int vld_cnt = 0;
  int start_cyc = 0;

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            rd_cyc[$];
  int            vld_cyc[$];

  always #5 clk = ~clk;

  pixel_feeder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .hold        (hold),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .data_out    (data_out),
    .vld         (vld),
    .last_data   (last_data),
    .busy        (busy),
    .done        (done)
`ifdef PIXEL_FEEDER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 16'h0200) return 32'h01020304;
    return {~a, a};
  endfunction

  // Memory model: one-cycle read latency, junk when not read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem_rd_en ? mem_fn(mem_addr) : 32'hDEADBEEF;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] n);
    for (int k = 0; k < int'(n); k++) begin
      logic [AW-1:0] a;
      a = b + AW'(k);
      addr_q.push_back(a);
      exp_q.push_back({mem_fn(a), (k == int'(n) - 1)});
    end
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int at);
    int i;
    for (i = 0; i < 200 && !done; i++) tick();
    at = cyc;
    check(nm, {63'd0, done}, 64'd1);
    tick();
    check({nm, "_single"}, {63'd0, done}, 64'd0);
  endtask

  // Monitor: pops expected addresses and words whenever the DUT presents them
  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      if (addr_q.size() == 0) check("rd_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
      else                    check("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
    end
    if (vld) begin
      vld_cnt++;
      vld_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("vld_unexpected", {31'd0, data_out, last_data}, 64'hFFFF_FFFF_FFFF);
      else                   check("word_data_last", {31'd0, data_out, last_data}, {31'd0, exp_q.pop_front()});
    end else if (rst_n) begin
      check("idle_zero", {31'd0, data_out, last_data}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, v0, d_at, nv;

    // Reset state
    #2;
    check("rst_vld",   {63'd0, vld}, 64'd0);
    check("rst_data",  64'(data_out), 64'd0);
    check("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic 4-word transfer, with an ignored start mid-transfer
    r0 = rd_cnt; v0 = vld_cnt; rd_cyc.delete(); vld_cyc.delete();
    run(16'h0010, 16'd4);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    tick();
    base_addr = 16'h0099; num_words = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("basic_done", d_at);
    repeat (3) tick();
    check("basic_rd_count",  64'(rd_cnt - r0), 64'd4);
    check("basic_vld_count", 64'(vld_cnt - v0), 64'd4);
    check("basic_busy_low",  {63'd0, busy}, 64'd0);
    if (rd_cyc.size() >= 4 && vld_cyc.size() >= 4) begin
      check("first_read_cycle", 64'(rd_cyc[0] - start_cyc), 64'd1);
      check("read_latency",     64'(vld_cyc[0] - rd_cyc[0]), 64'd2);
      check("reads_back2back",  64'(rd_cyc[3] - rd_cyc[0]), 64'd3);
      check("vld_back2back",    64'(vld_cyc[3] - vld_cyc[0]), 64'd3);
      check("done_after_last",  64'(d_at - rd_cyc[3]), 64'd4);
    end

    // Zero-length request
    r0 = rd_cnt; v0 = vld_cnt;
    run(16'h0030, 16'd0);
    wait_done("zero_done", d_at);
    check("zero_done_delay", 64'(d_at - start_cyc), 64'd2);
    check("zero_no_rd",  64'(rd_cnt - r0), 64'd0);
    check("zero_no_vld", 64'(vld_cnt - v0), 64'd0);

    // Address wrap
    r0 = rd_cnt;
    run(16'hFFFE, 16'd4);
    wait_done("wrap_done", d_at);
    check("wrap_rd_count", 64'(rd_cnt - r0), 64'd4);

    // Hold for 3 cycles after the 2nd of 6 reads
    v0 = vld_cnt; vld_cyc.delete();
    run(16'h0100, 16'd6);
    tick();
    tick();
    hold = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    wait_done("hold_done", d_at);
    check("hold_vld_count", 64'(vld_cnt - v0), 64'd6);
    if (vld_cyc.size() >= 6) begin
      check("hold_gap",    64'(vld_cyc[2] - vld_cyc[1]), 64'd4);
      check("hold_resume", 64'(vld_cyc[5] - vld_cyc[2]), 64'd3);
    end

    // Reset during word 3 of 8
    run(16'h0400, 16'd8);
    nv = 0;
    for (int i = 0; i < 50 && nv < 3; i++) begin
      tick();
      if (vld) nv++;
    end
    check("mid_reach_word3", 64'(nv), 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld_last", {62'd0, vld, last_data}, 64'd0);
    check("mid_rst_data",     64'(data_out), 64'd0);
    check("mid_rst_rd",       {31'd0, mem_rd_en, mem_addr, 16'd0}, 64'd0);
    check("mid_rst_busy_done", {62'd0, busy, done}, 64'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    v0 = vld_cnt; r0 = rd_cnt;
    repeat (12) tick();
    check("post_rst_no_vld", 64'(vld_cnt - v0), 64'd0);
    check("post_rst_no_rd",  64'(rd_cnt - r0), 64'd0);

    // Fresh transfer after the abort
    run(16'h0500, 16'd2);
    wait_done("post_rst_done", d_at);

`ifdef PIXEL_FEEDER_CHECKSUM_EN
    run(16'h0200, 16'd1);
    wait_done("cks_done", d_at);
    check("cks_value", 64'(checksum), 64'h000A);
    run(16'h0201, 16'd1);
    check("cks_cleared", 64'(checksum), 64'h0000);
    wait_done("cks_done2", d_at);
    check("cks_value2", 64'(checksum), 64'h01FE);
`endif

    repeat (3) tick();
    check("words_left",  64'(exp_q.size()), 64'd0);
    check("addrs_left",  64'(addr_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the streamed word width (32 or 64, a multiple of `COLOR_SIZE).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning the image memory word-address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, ports clk and rst_n.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to stream an image.
REQ-007 base_addr  input  ADDR_WIDTH  first memory word address, sampled at accepted start.
REQ-008 num_words  input  ADDR_WIDTH  number of words to stream, sampled at accepted start.
REQ-009 hold  input  1  pauses issuing new memory reads while high.
REQ-010 mem_rd_en  output  1  memory read strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  memory read address.
REQ-012 mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 data_out  output  DATA_WIDTH  pixel word to the brightness processor data_in.
REQ-014 vld  output  1  data_out valid.
REQ-015 last_data  output  1  marks the final word of the image, high only together with vld.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse when streaming has completed.

Function
REQ-018 The FSM SHALL have states IDLE, READ, DRAIN and FINISH.
REQ-019 In IDLE, start=1 with num_words>0 SHALL capture base_addr and num_words, assert busy and go to READ on the next edge.
REQ-020 In IDLE, start=1 with num_words=0 SHALL go to FINISH without any mem_rd_en or vld.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 In READ with hold=0, each cycle SHALL assert mem_rd_en with mem_addr = base_addr + issued_count, modulo 2^ADDR_WIDTH.
REQ-023 In READ with hold=1, mem_rd_en SHALL be 0; in-flight reads SHALL still complete.
REQ-024 After the read for word num_words-1 is issued, the FSM SHALL go to DRAIN.
REQ-025 A read issued at cycle t SHALL produce registered data_out=mem_rd_data with vld=1 at cycle t+2 (fixed latency 2); words SHALL appear in address order.
REQ-026 last_data SHALL be 1 exactly with the vld of word num_words-1.
REQ-027 DRAIN SHALL go to FINISH on the cycle the last word is emitted.
REQ-028 FINISH SHALL pulse done=1 for one cycle, drop busy and return to IDLE; a start in that same cycle SHALL be ignored.
REQ-029 When vld=0, data_out SHALL be 0 and last_data SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately force the FSM to IDLE and clear counters, in-flight tracking, data_out, vld, last_data, mem_rd_en, mem_addr, busy and done to 0, including in the middle of a transfer.
REQ-031 After reset is released, no word of an aborted transfer SHALL be emitted.

Configuration
REQ-032 Macro PIXEL_FEEDER_CHECKSUM_EN SHALL control the checksum feature.
REQ-033 With PIXEL_FEEDER_CHECKSUM_EN defined, the block SHALL add output checksum [15:0].
REQ-034 checksum SHALL be the sum, modulo 2^16, of every `COLOR_SIZE-bit pixel emitted with vld=1 since the last accepted start; it SHALL clear on accepted start and on reset, and be stable from done onward.
REQ-035 Without PIXEL_FEEDER_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 The shared package img_proc_pkg SHALL hold the feeder state enum typedef and the CHECKSUM_WIDTH=16 constant, alongside the existing `COLOR_SIZE definition.
REQ-037 Checksum accumulation SHALL be a sub-module pixel_checksum, instantiated only under PIXEL_FEEDER_CHECKSUM_EN.

Verification
REQ-038 start, base_addr=0x0010, num_words=4, hold=0 -> reads at addresses 0x10..0x13 on consecutive cycles; vld high for 4 cycles beginning 2 cycles after the first read; last_data on the 4th word; done pulses once.
REQ-039 num_words=0 -> no mem_rd_en and no vld; done pulses 2 cycles after start.
REQ-040 base_addr=0xFFFE, num_words=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-041 hold=1 for 3 cycles after the 2nd read of 6 -> exactly 6 words emitted in order with a 3-cycle vld gap; last_data only on the 6th word.
REQ-042 rst_n=0 during word 3 of 8 -> all outputs 0 immediately; after release, no vld occurs until a new start.
REQ-043 Checksum build, 1 word 0x01020304 with DATA_WIDTH=32 -> checksum=0x000A at done; a second start clears it.
